// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage owning the PC and a 2-entry {instr, pc} buffer
// feeding decode over valid/ready; redirects flush the buffer.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   redirect_valid/addr - redirect from execute (byte address, low bits dropped)
//   cmd_address_current - ROM byte address (= pc, word aligned)
//   current_instruction - combinational ROM data for cmd_address_current
//   dec_valid/ready     - handshake to decode
//   dec_instr, dec_pc   - buffer head entry
//   fetch_fault         - sticky out-of-range flag
//
// Optional feature macro: IFETCH_RANGE_CHECK_EN (blocks fetches at or
// beyond FW_LENGTH words and raises fetch_fault; undefined = no check).

module instr_fetch #(
   parameter int unsigned FW_LENGTH = 8,
   parameter int unsigned COUNTER_WIDTH = 12,
   parameter int unsigned INSTRUCTON_WIDTH = 32,
   parameter logic [COUNTER_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        redirect_valid,
   input  logic [COUNTER_WIDTH-1:0]    redirect_addr,
   output logic [COUNTER_WIDTH-1:0]    cmd_address_current,
   input  logic [INSTRUCTON_WIDTH-1:0] current_instruction,
   output logic                        dec_valid,
   input  logic                        dec_ready,
   output logic [INSTRUCTON_WIDTH-1:0] dec_instr,
   output logic [COUNTER_WIDTH-1:0]    dec_pc,
   output logic                        fetch_fault
);

   localparam logic [COUNTER_WIDTH-1:0] ALIGN_MASK =
      {{(COUNTER_WIDTH-2){1'b1}}, 2'b00};
   localparam logic [COUNTER_WIDTH-1:0] PC_STEP = COUNTER_WIDTH'(4);

   logic [COUNTER_WIDTH-1:0]    pc;
   logic [INSTRUCTON_WIDTH-1:0] head_instr;
   logic [INSTRUCTON_WIDTH-1:0] tail_instr;
   logic [COUNTER_WIDTH-1:0]    head_pc;
   logic [COUNTER_WIDTH-1:0]    tail_pc;
   logic [1:0]                  count;
   logic                        fault;
   logic                        pop;
   logic                        fetch_req;
   logic                        blocked;
   logic                        push;

   assign dec_valid = (count != 2'd0);
   assign pop       = dec_valid & dec_ready;

   // A full buffer can still accept a fetch when decode frees a slot.
   assign fetch_req = !redirect_valid & !fault &
                      ((count != 2'd2) | pop);

`ifdef IFETCH_RANGE_CHECK_EN
   localparam int unsigned FW_BYTES = FW_LENGTH * 4;

   logic out_of_range;

   assign out_of_range = (32'(pc) >= FW_BYTES);
   assign blocked      = fetch_req & out_of_range;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault <= 1'b0;
      end else if (redirect_valid) begin
         fault <= 1'b0;
      end else if (blocked) begin
         fault <= 1'b1;
      end
   end
`else
   assign blocked = 1'b0;
   assign fault   = 1'b0;
`endif

   assign push = fetch_req & !blocked;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_ADDR;
         count      <= 2'd0;
         head_instr <= '0;
         head_pc    <= '0;
         tail_instr <= '0;
         tail_pc    <= '0;
      end else if (redirect_valid) begin
         // Flush wins over any pop this cycle.
         count <= 2'd0;
         pc    <= redirect_addr & ALIGN_MASK;
      end else begin
         if (push) begin
            pc <= pc + PC_STEP;
         end
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_instr <= current_instruction;
                  head_pc    <= pc;
               end else begin
                  tail_instr <= current_instruction;
                  tail_pc    <= pc;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_instr <= tail_instr;
               head_pc    <= tail_pc;
               count      <= count - 2'd1;
            end
            2'b11: begin
               // Full: shift tail up and refill the freed slot.
               if (count == 2'd2) begin
                  head_instr <= tail_instr;
                  head_pc    <= tail_pc;
                  tail_instr <= current_instruction;
                  tail_pc    <= pc;
               end else begin
                  head_instr <= current_instruction;
                  head_pc    <= pc;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign cmd_address_current = pc;
   assign dec_instr           = head_instr;
   assign dec_pc              = head_pc;
   assign fetch_fault         = fault;

endmodule
